// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and byte-mask helper for the LSU
// Contents:
//   MODE_B/MODE_H/MODE_W : access-size encodings carried on req_mode
//   state_e              : sequencer states IDLE, A0, A1, CAP, RESP
//   byte_mask()          : low-aligned byte mask for a mode, 0 for an illegal mode
package lsu_pkg;

  localparam logic [2:0] MODE_B = 3'b001;
  localparam logic [2:0] MODE_H = 3'b010;
  localparam logic [2:0] MODE_W = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A0   = 3'd1,
    ST_A1   = 3'd2,
    ST_CAP  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // An all-zero mask doubles as the illegal-mode indicator.
  function automatic logic [3:0] byte_mask(input logic [2:0] mode);
    case (mode)
      MODE_B:  return 4'b0001;
      MODE_H:  return 4'b0011;
      MODE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane steering for stores and merge/extend for loads
// Ports:
//   mode_i     : access size (MODE_B/H/W)
//   k_i        : byte offset within the first word
//   wdata_i    : right-justified store data
//   unsigned_i : zero-extend loads
//   rdata0_i   : first-beat read word
//   rdata1_i   : second-beat read word (0 when not split)
//   be_o       : {be1,be0} byte enables for the two beats
//   wd_o       : {wd1,wd0} lane-shifted write data for the two beats
//   split_o    : access touches the second word
//   ldata_o    : realigned, extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] wdata_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  output logic [7:0]  be_o,
  output logic [63:0] wd_o,
  output logic        split_o,
  output logic [31:0] ldata_o
);

  logic [31:0] merged;

  assign be_o    = {4'b0000, byte_mask(mode_i)} << k_i;
  assign wd_o    = {32'h0, wdata_i} << {k_i, 3'b000};
  assign split_o = |be_o[7:4];

  // Only the low word of the shifted pair can hold the requested bytes.
  assign merged = 32'({rdata1_i, rdata0_i} >> {k_i, 3'b000});

  always_comb begin
    ldata_o = merged;
    case (mode_i)
      MODE_B:  ldata_o = {{24{merged[7] & ~unsigned_i}}, merged[7:0]};
      MODE_H:  ldata_o = {{16{merged[15] & ~unsigned_i}}, merged[15:0]};
      default: ldata_o = merged;
    endcase
  end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// rtl/lsu_sram_ctrl.sv - load/store sequencer between MEM stage and single-port data SRAM
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake (ready only in IDLE, not in reset)
//   req_we, req_mode, req_unsigned, req_addr, req_wdata : access description
//   resp_valid/resp_ready       : response handshake
//   resp_rdata, resp_err        : extended load data, illegal/rejected access flag
//   data_sram_en/we/addr/wdata  : SRAM strobe, byte enables, word address, lane data
//   data_sram_rdata             : SRAM read data, valid the cycle after en
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_we,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata
);

  state_e            state_q, state_d;
  logic              we_q, uns_q, resp_err_q;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata0_q, resp_rdata_q;

  logic [7:0]        be, req_be;
  logic [63:0]       wd;
  logic              split, req_err;
  logic [31:0]       ldata, cap_r0, cap_r1;
  logic [ADDR_W-1:0] beat0, beat1;

  // Error decision is made on the live request so errors respond one cycle after accept.
  assign req_be  = {4'b0000, byte_mask(req_mode)} << req_addr[1:0];
  assign req_err = (byte_mask(req_mode) == 4'b0000) || ((|req_be[7:4]) && !SPLIT_EN);

  assign beat0 = {addr_q[ADDR_W-1:2], 2'b00};
  assign beat1 = beat0 + ADDR_W'(4);

  // In CAP the SRAM output holds the last beat: beat1 when split, else beat0.
  assign cap_r1 = split ? data_sram_rdata : 32'h0;
  assign cap_r0 = split ? rdata0_q : data_sram_rdata;

  lsu_align u_align (
    .mode_i     (mode_q),
    .k_i        (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .unsigned_i (uns_q),
    .rdata0_i   (cap_r0),
    .rdata1_i   (cap_r1),
    .be_o       (be),
    .wd_o       (wd),
    .split_o    (split),
    .ldata_o    (ldata)
  );

  assign resp_rdata = reset ? 32'h0 : resp_rdata_q;
  assign resp_err   = reset ? 1'b0 : resp_err_q;

  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = 32'h0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? ST_RESP : ST_A0;
      end
      ST_A0: begin
        data_sram_en    = 1'b1;
        data_sram_addr  = beat0;
        data_sram_we    = we_q ? be[3:0] : 4'b0000;
        data_sram_wdata = wd[31:0];
        if (split)      state_d = ST_A1;
        else if (!we_q) state_d = ST_CAP;
        else            state_d = ST_RESP;
      end
      ST_A1: begin
        data_sram_en    = 1'b1;
        data_sram_addr  = beat1;
        data_sram_we    = we_q ? be[7:4] : 4'b0000;
        data_sram_wdata = wd[63:32];
        state_d         = we_q ? ST_RESP : ST_CAP;
      end
      ST_CAP:  state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset suppresses any beat in flight, including a pending beat1.
    if (reset) begin
      state_d         = ST_IDLE;
      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_we    = 4'b0000;
      data_sram_addr  = '0;
      data_sram_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      mode_q       <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata0_q     <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        we_q         <= req_we;
        uns_q        <= req_unsigned;
        mode_q       <= req_mode;
        addr_q       <= req_addr;
        wdata_q      <= req_wdata;
        resp_rdata_q <= 32'h0;
        resp_err_q   <= req_err;
      end
      if (state_q == ST_A1) rdata0_q <= data_sram_rdata;
      if (state_q == ST_CAP) resp_rdata_q <= ldata;
    end
  end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// tb/tb_lsu_sram_ctrl.sv - directed scoreboard bench for lsu_sram_ctrl
module tb_lsu_sram_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  logic        clk, reset, resp_ready;
  logic        v0, v1, req_we, req_unsigned;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata;

  logic        ready0, rv0, err0, en0;
  logic [31:0] rdata0, addr0, wd0, s_rdata;
  logic [3:0]  we0;
  logic        ready1, rv1, err1, en1;
  logic [31:0] rdata1, addr1, wd1;
  logic [3:0]  we1;

  logic [31:0] mem [16];
  beat_t beat_q[$];
  resp_t resp_q[$];
  int total, bad;

  lsu_sram_ctrl #(.ADDR_W(32), .SPLIT_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(ready0), .req_we(req_we),
    .req_mode(req_mode), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rdata0), .resp_err(err0), .data_sram_en(en0), .data_sram_we(we0),
    .data_sram_addr(addr0), .data_sram_wdata(wd0), .data_sram_rdata(s_rdata)
  );

  lsu_sram_ctrl #(.ADDR_W(32), .SPLIT_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(ready1), .req_we(req_we),
    .req_mode(req_mode), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rdata1), .resp_err(err1), .data_sram_en(en1), .data_sram_we(we1),
    .data_sram_addr(addr1), .data_sram_wdata(wd1), .data_sram_rdata(32'h0)
  );

  always #5 clk = ~clk;

  // Single-port SRAM model: byte writes, registered read one cycle after en.
  always @(posedge clk) begin
    if (en0) begin
      for (int i = 0; i < 4; i++)
        if (we0[i]) mem[addr0[5:2]][8*i +: 8] <= wd0[8*i +: 8];
      s_rdata <= mem[addr0[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.we = w; b.wdata = d;
    beat_q.push_back(b);
  endtask

  task automatic push_resp(input logic [31:0] r, input logic e, input int lat);
    resp_t x;
    x.rdata = r; x.err = e; x.lat = lat;
    resp_q.push_back(x);
  endtask

  task automatic run(input logic we, input logic [2:0] mode, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    bit    done;
    beat_t b;
    resp_t e;
    req_we = we; req_mode = mode; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    v0 = 1'b1;
    chk("req_ready_idle", ready0, 1);
    @(posedge clk);
    #1 v0 = 1'b0;
    done = 0;
    for (int n = 1; n <= 8 && !done; n++) begin
      @(negedge clk);
      if (en0) begin
        total++;
        assert (beat_q.size() != 0) else begin
          bad++;
          $error("FAIL extra_beat observed addr=%h we=%b expected no beat", addr0, we0);
        end
        if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          chk("beat_addr", addr0, b.addr);
          chk("beat_we", we0, b.we);
          chk("beat_wdata", wd0, b.wdata);
        end
      end
      if (rv0 && resp_q.size() != 0) begin
        e = resp_q.pop_front();
        chk("resp_lat", n, e.lat);
        chk("resp_rdata", rdata0, e.rdata);
        chk("resp_err", err0, e.err);
        chk("req_ready_busy", ready0, 0);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          chk("hold_valid", rv0, 1);
          chk("hold_rdata", rdata0, e.rdata);
          chk("hold_ready", ready0, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL resp_timeout observed=none expected=response");
    end
    chk("beats_left", beat_q.size(), 0);
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 0; reset = 1; resp_ready = 1; v0 = 0; v1 = 0;
    req_we = 0; req_mode = 3'b001; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", ready0, 0);
    chk("rst_en", en0, 0);
    chk("rst_resp_valid", rv0, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("idle_req_ready", ready0, 1);
    chk("idle_en", en0, 0);
    chk("idle_resp_rdata", rdata0, 0);
    chk("idle_resp_err", err0, 0);

    // 1: aligned word store
    push_beat(32'h100, 4'b1111, 32'hf1f2f3f4); push_resp(0, 0, 2);
    run(1, 3'b100, 0, 32'h100, 32'hf1f2f3f4, 0);
    // 2: byte store top lane
    push_beat(32'h100, 4'b1000, 32'hf4000000); push_resp(0, 0, 2);
    run(1, 3'b001, 0, 32'h103, 32'hf1f2f3f4, 0);
    // 3: word store crossing a word boundary
    push_beat(32'h100, 4'b1100, 32'hf3f40000);
    push_beat(32'h104, 4'b0011, 32'h0000f1f2); push_resp(0, 0, 3);
    run(1, 3'b100, 0, 32'h102, 32'hf1f2f3f4, 0);
    // preload load operands
    push_beat(32'h104, 4'b1111, 32'h80112233); push_resp(0, 0, 2);
    run(1, 3'b100, 0, 32'h104, 32'h80112233, 0);
    push_beat(32'h108, 4'b1111, 32'h445566ff); push_resp(0, 0, 2);
    run(1, 3'b100, 0, 32'h108, 32'h445566ff, 0);
    // 4: split half load, signed then unsigned with response backpressure
    push_beat(32'h104, 4'b0000, 0); push_beat(32'h108, 4'b0000, 0);
    push_resp(32'hFFFFFF80, 0, 4);
    run(0, 3'b010, 0, 32'h107, 0, 0);
    push_beat(32'h104, 4'b0000, 0); push_beat(32'h108, 4'b0000, 0);
    push_resp(32'h0000FF80, 0, 4);
    resp_ready = 0;
    run(0, 3'b010, 1, 32'h107, 0, 3);
    // aligned loads: signed byte, unsigned byte, word
    push_beat(32'h104, 4'b0000, 0); push_resp(32'hFFFFFF80, 0, 3);
    run(0, 3'b001, 0, 32'h107, 0, 0);
    push_beat(32'h104, 4'b0000, 0); push_resp(32'h00000022, 0, 3);
    run(0, 3'b001, 1, 32'h105, 0, 0);
    push_beat(32'h108, 4'b0000, 0); push_resp(32'h445566ff, 0, 3);
    run(0, 3'b100, 0, 32'h108, 0, 0);
    // split store at top of address space wraps beat1 to 0
    push_beat(32'hFFFFFFFC, 4'b1000, 32'hcd000000);
    push_beat(32'h00000000, 4'b0001, 32'h000000ab); push_resp(0, 0, 3);
    run(1, 3'b010, 0, 32'hFFFFFFFF, 32'h0000abcd, 0);
    // 5: illegal mode
    push_resp(0, 1, 1);
    run(0, 3'b011, 0, 32'h100, 0, 0);
    // 5b: crossing access rejected when splitting is disabled
    req_we = 0; req_mode = 3'b100; req_unsigned = 0; req_addr = 32'h101; req_wdata = 0;
    v1 = 1;
    chk("nosplit_ready", ready1, 1);
    @(posedge clk);
    #1 v1 = 0;
    @(negedge clk);
    chk("nosplit_resp_valid", rv1, 1);
    chk("nosplit_resp_err", err1, 1);
    chk("nosplit_rdata", rdata1, 0);
    chk("nosplit_en", en1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("nosplit_idle", ready1, 1);
    chk("nosplit_en_after", en1, 0);
    // 6: reset during beat1 of a split store
    req_we = 1; req_mode = 3'b100; req_addr = 32'h102; req_wdata = 32'hf1f2f3f4;
    v0 = 1;
    @(posedge clk);
    #1 v0 = 0;
    @(negedge clk);
    chk("rst6_beat0_en", en0, 1);
    chk("rst6_beat0_addr", addr0, 32'h100);
    chk("rst6_beat0_we", we0, 4'b1100);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst6_a1_en", en0, 0);
    chk("rst6_a1_we", we0, 0);
    chk("rst6_a1_resp", rv0, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst6_idle_ready", ready0, 1);
    chk("rst6_idle_en", en0, 0);
    chk("rst6_idle_resp", rv0, 0);
    push_beat(32'h200, 4'b1111, 32'h12345678); push_resp(0, 0, 2);
    run(1, 3'b100, 0, 32'h200, 32'h12345678, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
